// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor
// master drives start/A/B/Bin; slave returns busy/done/Diff/Bout
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
  modport slave (input start, A, B, Bin, output busy, done, Diff, Bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial {Bout,Diff} = A - B - Bin, one bit per cycle, LSB first
// ports: clk, rst (async, active-high), bus (slave: start/A/B/Bin in, busy/done/Diff/Bout out)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, d_bit, br_next, last;
  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        a_d     = bus.A;
        b_d     = bus.B;
        br_d    = bus.Bin;
        res_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        // result fills from the top so the LSB lands at bit 0 after WIDTH shifts
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end
  assign bus.busy = state_q == SHIFT;
  assign bus.done = state_q == DONE;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide port A  input  WIDTH  minuend; sampled with start.
REQ-006 SHALL provide port B  input  WIDTH  subtrahend; sampled with start.
REQ-007 SHALL provide port Bin  input  1  borrow-in; sampled with start.
REQ-008 SHALL provide port busy  output  1  high while bits are being processed.
REQ-009 SHALL provide port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL provide port Diff  output  WIDTH  registered difference.
REQ-011 SHALL provide port Bout  output  1  registered borrow-out.

Function
REQ-012 SHALL compute {Bout,Diff} = A - B - Bin modulo 2^(WIDTH+1); Bout=1 iff A < B+Bin (unsigned).
REQ-013 SHALL process one bit per cycle, LSB first, via full-subtractor cell: d = a^b^br; br_next = (~a&b) | (~(a^b)&br); br initialised to Bin.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; no other reachable states.
REQ-015 IDLE: start=1 at edge k -> latch A, B, Bin into shift/borrow registers, clear bit counter, enter SHIFT; start=0 -> remain IDLE.
REQ-016 SHIFT: each edge processes one bit and increments counter; after the WIDTH-th bit (edge k+WIDTH) -> enter DONE.
REQ-017 On SHIFT->DONE edge, Diff SHALL load the assembled WIDTH-bit result and Bout the final borrow.
REQ-018 DONE: lasts exactly one cycle, then IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in SHIFT (cycles k+1..k+WIDTH); done SHALL be 1 exactly in DONE (cycle k+WIDTH+1).
REQ-020 Latency start-sample to done = WIDTH+1 cycles; with start held high, issue interval = WIDTH+2 cycles.
REQ-021 start while in SHIFT or DONE SHALL be ignored; in-flight operands unaffected.
REQ-022 Changes on A/B/Bin after the sampling edge SHALL NOT affect the result.
REQ-023 Diff and Bout SHALL hold last result until the next SHIFT->DONE edge.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, Diff=0, Bout=0, counter=0, internal registers=0.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation; no done pulse; Diff/Bout read 0.
REQ-026 After rst release, first start sampled in IDLE SHALL operate normally.

Verification
REQ-027 A=0x5A, B=0x23, Bin=0, start 1 cycle -> busy 8 cycles, done at cycle 9, Diff=0x37, Bout=0.
REQ-028 A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1; A=0xFF, B=0xFF, Bin=1 -> Diff=0xFF, Bout=1.
REQ-029 A=0x80, B=0x7F, Bin=1 -> Diff=0x00, Bout=0; A/B changed to 0x00 during SHIFT -> result unchanged.
REQ-030 start held high, operands (0x10,0x01,0),(0x01,0x10,0) -> done pulses 10 cycles apart, Diff=0x0F/Bout=0 then Diff=0xF1/Bout=1; Diff unchanged between pulses.
REQ-031 rst pulsed after 4th SHIFT cycle -> outputs 0 same cycle, no done; subsequent A=0x09, B=0x04, Bin=0 -> Diff=0x05, Bout=0.
REQ-032 Random 10k operations SHALL match reference model of REQ-012, with busy/done timing per REQ-019.
